pc_gen: RTL and testbench

- Parametrised next-generation program-counter unit for the core front end.
- Holds the current fetch PC and presents it to instruction fetch under a valid/ready handshake.
- Selects the next PC from: reset vector, execute-stage redirect, return-address-stack (RAS) pop, or sequential increment.
- Adds stall, halt/resume and misaligned-redirect detection, none of which the base PC register provides.

---
 rtl/pc_gen_pkg.sv | 17 +
 rtl/pc_gen_ras.sv | 49 ++++
 rtl/pc_gen.sv | 104 ++++++++++
 tb/tb_pc_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types and helpers for the program-counter unit
package pc_gen_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_gen_state_e;

  // Number of low PC bits that must be zero for an aligned fetch address.
  function automatic int align_width(input int instr_bytes);
    return $clog2(instr_bytes);
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - circular return-address stack; the oldest entry is overwritten when full
module pc_gen_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top_addr,
  output logic            empty,
  output logic            full,
  output logic            underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   top;
  logic [CW-1:0]   count;

  assign top_addr = mem[top];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      top       <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= pop && empty;
      if (pop && !empty && push) begin
        // Caller consumes the old top; the new return address takes its slot.
        mem[top] <= push_addr;
      end else if (pop && !empty) begin
        top   <= top - PW'(1);
        count <= count - CW'(1);
      end else if (push) begin
        mem[top + PW'(1)] <= push_addr;
        top               <= top + PW'(1);
        if (!full) count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with boot/run/halt control, redirect and RAS return selection
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_fetch_ready,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_ras_push,
  input  logic [XLEN-1:0] i_ras_push_addr,
  input  logic            i_ras_pop,
  input  logic            i_halt_req,
  input  logic            i_resume,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pc_valid,
  output logic            o_misaligned,
  output logic            o_ras_empty,
  output logic            o_ras_full,
  output logic            o_ras_underflow,
  output logic [1:0]      o_state
);

  localparam int              ALIGN_W    = align_width(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_W) - 64'd1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  pc_gen_state_e   state;
  logic            ras_en;
  logic [XLEN-1:0] ras_top;
  logic            redirect_misaligned;

  // A halt request freezes the stack as well as the PC on that edge.
  assign ras_en              = (state == RUN) && !i_halt_req;
  assign redirect_misaligned = |(i_redirect_pc & ALIGN_MASK);
  assign o_state             = state;

  pc_gen_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (i_ras_push && ras_en),
    .pop       (i_ras_pop && ras_en),
    .push_addr (i_ras_push_addr),
    .top_addr  (ras_top),
    .empty     (o_ras_empty),
    .full      (o_ras_full),
    .underflow (o_ras_underflow)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= BOOT;
      o_pc         <= RESET_VECTOR;
      o_pc_valid   <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          o_pc_valid <= 1'b1;
        end
        RUN: begin
          if (i_halt_req) begin
            state      <= HALT;
            o_pc_valid <= 1'b0;
          end else if (i_redirect_valid) begin
            if (redirect_misaligned) begin
              o_misaligned <= 1'b1;
              state        <= HALT;
              o_pc_valid   <= 1'b0;
            end else begin
              o_pc <= i_redirect_pc;
            end
          end else if (i_ras_pop && !o_ras_empty) begin
            o_pc <= ras_top;
          end else if (o_pc_valid && i_fetch_ready && !i_stall) begin
            o_pc <= o_pc + PC_STEP;
          end
        end
        HALT: begin
          if (i_resume) begin
            state        <= RUN;
            o_pc_valid   <= 1'b1;
            o_misaligned <= 1'b0;
          end
        end
        default: begin
          state      <= BOOT;
          o_pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed checks of pc_gen against a queue-based reference model
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_ready, redirect_valid, ras_push, ras_pop, halt_req, resume;
  logic [31:0] redirect_pc, ras_push_addr;
  logic [31:0] pc;
  logic        pc_valid, misaligned, ras_empty, ras_full, ras_underflow;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_stall          (stall),
    .i_fetch_ready    (fetch_ready),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_ras_push       (ras_push),
    .i_ras_push_addr  (ras_push_addr),
    .i_ras_pop        (ras_pop),
    .i_halt_req       (halt_req),
    .i_resume         (resume),
    .o_pc             (pc),
    .o_pc_valid       (pc_valid),
    .o_misaligned     (misaligned),
    .o_ras_empty      (ras_empty),
    .o_ras_full       (ras_full),
    .o_ras_underflow  (ras_underflow),
    .o_state          (state)
  );

  // Reference model: 0=boot 1=run 2=halt, return stack as a queue (back = top)
  int          m_state = 0;
  logic [31:0] m_pc    = 32'h0;
  bit          m_mis   = 1'b0;
  bit          m_uf    = 1'b0;
  logic [31:0] m_ras[$];

  always @(posedge clk) begin
    logic [31:0] popped;
    bit          have_pop;
    if (reset) begin
      m_state = 0;
      m_pc    = 32'h0;
      m_mis   = 1'b0;
      m_uf    = 1'b0;
      m_ras.delete();
    end else begin
      m_uf = 1'b0;
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        if (halt_req) begin
          m_state = 2;
        end else begin
          have_pop = ras_pop && (m_ras.size() > 0);
          popped   = have_pop ? m_ras[$] : 32'h0;
          if (ras_pop && m_ras.size() == 0) m_uf = 1'b1;
          if (have_pop) void'(m_ras.pop_back());
          if (ras_push) begin
            m_ras.push_back(ras_push_addr);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
          if (redirect_valid) begin
            if (redirect_pc % 4 != 0) begin
              m_mis   = 1'b1;
              m_state = 2;
            end else begin
              m_pc = redirect_pc;
            end
          end else if (have_pop) begin
            m_pc = popped;
          end else if (fetch_ready && !stall) begin
            m_pc = m_pc + 32'd4;
          end
        end
      end else if (resume) begin
        m_state = 1;
        m_mis   = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("pc",        pc,                   m_pc);
    chk("pc_valid",  {31'b0, pc_valid},    {31'b0, m_state == 1});
    chk("state",     {30'b0, state},       m_state);
    chk("misalign",  {31'b0, misaligned},  {31'b0, m_mis});
    chk("ras_empty", {31'b0, ras_empty},   {31'b0, m_ras.size() == 0});
    chk("ras_full",  {31'b0, ras_full},    {31'b0, m_ras.size() == 4});
    chk("underflow", {31'b0, ras_underflow}, {31'b0, m_uf});
  end

  task automatic idle();
    reset = 1'b0; stall = 1'b0; fetch_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; ras_push = 1'b0; ras_push_addr = 32'h0; ras_pop = 1'b0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    idle();
    reset = 1'b1;
    cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_state", {30'b0, state}, 32'd0);
    chk("rst_empty", {31'b0, ras_empty}, 32'd1);
    reset = 1'b0;
    cyc();
    chk("boot_exit_state", {30'b0, state}, 32'd1);
    chk("run_pc0", pc, 32'h0);
    cyc(); chk("run_pc4", pc, 32'h4);
    cyc(); chk("run_pc8", pc, 32'h8);
    cyc(); chk("run_pc12", pc, 32'hC);

    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc(); chk("redir_stall", pc, 32'h100);
    redirect_valid = 1'b0;
    cyc(); chk("stall_hold", pc, 32'h100);
    stall = 1'b0;
    cyc(); chk("unstall", pc, 32'h104);

    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cyc();
    chk("mis_pc", pc, 32'h104);
    chk("mis_flag", {31'b0, misaligned}, 32'd1);
    chk("mis_state", {30'b0, state}, 32'd2);
    redirect_valid = 1'b0; resume = 1'b1;
    cyc();
    chk("resume_state", {30'b0, state}, 32'd1);
    chk("resume_mis", {31'b0, misaligned}, 32'd0);
    resume = 1'b0;

    ras_push = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      ras_push_addr = 32'(i * 16);
      cyc();
    end
    ras_push = 1'b0;
    chk("ras_full", {31'b0, ras_full}, 32'd1);
    ras_pop = 1'b1;
    for (int i = 5; i >= 2; i--) begin
      cyc();
      chk("ras_pop_pc", pc, 32'(i * 16));
    end
    cyc();
    chk("ras_uflow", {31'b0, ras_underflow}, 32'd1);
    chk("uflow_adv", pc, 32'h24);
    ras_pop = 1'b0;
    cyc();
    chk("uflow_pulse", {31'b0, ras_underflow}, 32'd0);

    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); chk("wrap_top", pc, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    cyc(); chk("wrap_zero", pc, 32'h0);

    ras_push = 1'b1; ras_push_addr = 32'h80;
    cyc(); ras_push = 1'b0; halt_req = 1'b1;
    cyc(); chk("halt_state", {30'b0, state}, 32'd2);
    halt_req = 1'b0; reset = 1'b1;
    cyc();
    chk("rst_halt_pc", pc, 32'h0);
    chk("rst_halt_empty", {31'b0, ras_empty}, 32'd1);
    chk("rst_halt_state", {30'b0, state}, 32'd0);
    reset = 1'b0;
    cyc(); chk("rst_halt_run", {30'b0, state}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 299) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      r = $urandom();
      if ($urandom_range(0, 3) == 0) r[1:0] = 2'($urandom_range(1, 3));
      else r[1:0] = 2'b00;
      redirect_pc    = r;
      ras_push       = ($urandom_range(0, 5) == 0);
      r = $urandom();
      r[1:0] = 2'b00;
      ras_push_addr  = r;
      ras_pop        = ($urandom_range(0, 5) == 0);
      halt_req       = ($urandom_range(0, 29) == 0);
      resume         = ($urandom_range(0, 3) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
